// File: rtl/water_pkg.sv
// Shared types and constants for the water-box level path (sequencer and encoder).
package water_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StDrain = 2'd2
  } water_state_e;

  localparam logic [2:0] LEVEL_MAX = 3'd7;
  localparam logic [2:0] LEVEL_MIN = 3'd0;
  localparam logic       DIR_UP    = 1'b1;
  localparam logic       DIR_DOWN  = 1'b0;

  localparam int unsigned TICK_CNT_W = 4;

endpackage

// File: rtl/water_step_divider.sv
// Counts enabled ticks and emits a one-cycle step pulse every STEP_TICKS of them.
module water_step_divider
  import water_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  enable_i,
  output logic                  step_o,
  output logic [TICK_CNT_W-1:0] tick_cnt_o
);

  localparam logic [TICK_CNT_W-1:0] LastTick = TICK_CNT_W'(STEP_TICKS - 1);

  logic [TICK_CNT_W-1:0] tick_cnt_d, tick_cnt_q;

  // Step is combinational so the count update lands on the qualifying tick's edge.
  assign step_o     = enable_i && (tick_cnt_q == LastTick);
  assign tick_cnt_o = tick_cnt_q;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clear_i) begin
      tick_cnt_d = '0;
    end else if (enable_i) begin
      tick_cnt_d = (tick_cnt_q == LastTick) ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/water_level_sequencer.sv
// Fill/drain FSM producing the 3-bit tank count and direction for the level encoder.
// Optional WATER_AUTO_CYCLE_EN: bounces between 0 and 7 instead of stopping at the bounds.
module water_level_sequencer
  import water_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 4,
  parameter int unsigned INIT_LEVEL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       fill_req,
  input  logic       drain_req,
  input  logic       hold,
  output logic [2:0] count_0_7,
  output logic       direction,
  output logic       full,
  output logic       empty,
  output logic       moving
);

  localparam logic [2:0] InitLevel = 3'(INIT_LEVEL);

  water_state_e state_d, state_q;
  logic [2:0]   count_d, count_q;
  logic         dir_d, dir_q;
  logic         full_q, empty_q, moving_q;
  logic         clear, enable, step;
  logic         fill_only, drain_only;
  logic [TICK_CNT_W-1:0] tick_cnt;

  assign fill_only  = fill_req && !drain_req;
  assign drain_only = drain_req && !fill_req;
  assign enable     = tick && !hold && (state_q != StIdle);

  water_step_divider #(
    .STEP_TICKS(STEP_TICKS)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .enable_i  (enable),
    .step_o    (step),
    .tick_cnt_o(tick_cnt)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    clear   = 1'b0;
    case (state_q)
      StIdle: begin
        if (fill_only && count_q != LEVEL_MAX) begin
          state_d = StFill;
          dir_d   = DIR_UP;
          clear   = 1'b1;
        end else if (drain_only && count_q != LEVEL_MIN) begin
          state_d = StDrain;
          dir_d   = DIR_DOWN;
          clear   = 1'b1;
        end
      end
      StFill: begin
        if (drain_only && count_q != LEVEL_MIN) begin
          state_d = StDrain;
          dir_d   = DIR_DOWN;
          clear   = 1'b1;
`ifdef WATER_AUTO_CYCLE_EN
        end else if (fill_req && drain_req) begin
          state_d = StIdle;
`endif
        end else if (step) begin
          count_d = count_q + 3'd1;
          if (count_d == LEVEL_MAX) begin
`ifdef WATER_AUTO_CYCLE_EN
            state_d = StDrain;
            dir_d   = DIR_DOWN;
            clear   = 1'b1;
`else
            state_d = StIdle;
`endif
          end
        end
      end
      StDrain: begin
        if (fill_only && count_q != LEVEL_MAX) begin
          state_d = StFill;
          dir_d   = DIR_UP;
          clear   = 1'b1;
`ifdef WATER_AUTO_CYCLE_EN
        end else if (fill_req && drain_req) begin
          state_d = StIdle;
`endif
        end else if (step) begin
          count_d = count_q - 3'd1;
          if (count_d == LEVEL_MIN) begin
`ifdef WATER_AUTO_CYCLE_EN
            state_d = StFill;
            dir_d   = DIR_UP;
            clear   = 1'b1;
`else
            state_d = StIdle;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Flags are computed from next-state values so they align with count/state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= InitLevel;
      dir_q    <= DIR_DOWN;
      full_q   <= (InitLevel == LEVEL_MAX);
      empty_q  <= (InitLevel == LEVEL_MIN);
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      full_q   <= (count_d == LEVEL_MAX);
      empty_q  <= (count_d == LEVEL_MIN);
      moving_q <= (state_d != StIdle);
    end
  end

  assign count_0_7 = count_q;
  assign direction = dir_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign moving    = moving_q;

endmodule

// File: tb/tb_water_level_sequencer.sv
// Directed bench for water_level_sequencer: vector table plus multi-cycle corner sequences.
module tb_water_level_sequencer;
  import water_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, fill_req = 1'b0, drain_req = 1'b0, hold = 1'b0;
  logic       fill2 = 1'b0, drain2 = 1'b0;
  logic [2:0] count_0_7, count2;
  logic       direction, full, empty, moving;
  logic       dir2, full2, empty2, moving2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  water_level_sequencer #(.STEP_TICKS(4), .INIT_LEVEL(0)) dut (
    .clk(clk), .reset(reset), .tick(tick), .fill_req(fill_req), .drain_req(drain_req),
    .hold(hold), .count_0_7(count_0_7), .direction(direction), .full(full), .empty(empty),
    .moving(moving)
  );

  water_level_sequencer #(.STEP_TICKS(4), .INIT_LEVEL(4)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .fill_req(fill2), .drain_req(drain2),
    .hold(hold), .count_0_7(count2), .direction(dir2), .full(full2), .empty(empty2),
    .moving(moving2)
  );

  typedef struct {
    logic f, d, h, t;
    int   cnt, dir, mov, full, empty, tcnt;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  initial begin
    //            f     d     h     t    cnt dir mov full empty tcnt
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1, 0};  // drain at 0 ignored
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1, 0};  // both in idle
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1, 0, 1, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 1, 1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 1, 0, 1, 1};  // hold blocks tick
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1, 0, 1, 1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 1, 2};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 1, 3};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1, 0, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 1, 0, 0, 1};  // both while moving
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 0, 0};  // reversal
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1, 0, 0, 1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1, 0, 0, 2};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1, 0, 0, 3};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1, 0};

    #1 reset = 1'b1;
    #2;
    chk("rst_count", int'(count_0_7), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_dir", int'(direction), 0);
    chk("rst2_count", int'(count2), 4);
    chk("rst2_flags", int'({full2, empty2, moving2}), 0);
    cyc();
    @(negedge clk);
    reset = 1'b0;

`ifdef WATER_AUTO_CYCLE_EN
    fill_req = 1'b1;
    cyc();
    fill_req = 1'b0;
    for (int i = 1; i <= 56; i++) begin
      tick = 1'b1;
      cyc();
      chk("auto_count", int'(count_0_7), (i <= 28) ? i / 4 : 7 - (i - 28) / 4);
      chk("auto_moving", int'(moving), 1);
      if (i == 28) chk("auto_dir_top", int'(direction), 0);
      if (i == 56) chk("auto_dir_bot", int'(direction), 1);
    end
    tick = 1'b0;
    fill_req = 1'b1;
    drain_req = 1'b1;
    cyc();
    fill_req = 1'b0;
    drain_req = 1'b0;
    chk("auto_both_idle", int'(moving), 0);
    chk("auto_both_state", int'(dut.state_q), int'(StIdle));
`else
    for (int i = 0; i < 15; i++) begin
      fill_req = vecs[i].f;
      drain_req = vecs[i].d;
      hold = vecs[i].h;
      tick = vecs[i].t;
      cyc();
      chk($sformatf("v%0d_count", i), int'(count_0_7), vecs[i].cnt);
      chk($sformatf("v%0d_dir", i), int'(direction), vecs[i].dir);
      chk($sformatf("v%0d_moving", i), int'(moving), vecs[i].mov);
      chk($sformatf("v%0d_full", i), int'(full), vecs[i].full);
      chk($sformatf("v%0d_empty", i), int'(empty), vecs[i].empty);
      chk($sformatf("v%0d_tcnt", i), int'(dut.u_div.tick_cnt_o), vecs[i].tcnt);
    end
    {fill_req, drain_req, hold, tick} = 4'b0;

    // Fill 0 -> 7 with fill_req held.
    fill_req = 1'b1;
    cyc();
    for (int i = 1; i <= 28; i++) begin
      tick = 1'b1;
      cyc();
      if (i == 4) chk("fill_cnt1", int'(count_0_7), 1);
      if (i == 27) chk("fill_cnt6_moving", int'({count_0_7, moving}), 13);
      if (i == 28) begin
        chk("fill_cnt7", int'(count_0_7), 7);
        chk("fill_full", int'(full), 1);
        chk("fill_moving", int'(moving), 0);
        chk("fill_dir", int'(direction), 1);
        chk("fill_empty", int'(empty), 0);
      end
    end
    cyc();
    chk("fill_at_top_idle", int'({count_0_7, moving}), 14);
    tick = 1'b0;
    fill_req = 1'b0;

    // Drain 7 -> 0 from a single pulse.
    drain_req = 1'b1;
    cyc();
    drain_req = 1'b0;
    chk("drain_start_moving", int'(moving), 1);
    chk("drain_start_dir", int'(direction), 0);
    for (int i = 1; i <= 28; i++) begin
      tick = 1'b1;
      cyc();
      if (i == 4) chk("drain_cnt6", int'(count_0_7), 6);
      if (i == 28) begin
        chk("drain_cnt0", int'(count_0_7), 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_moving", int'(moving), 0);
      end
    end
    tick = 1'b0;
    drain_req = 1'b1;
    cyc();
    drain_req = 1'b0;
    chk("drain_at_bot_state", int'(dut.state_q), int'(StIdle));
    chk("drain_at_bot_moving", int'(moving), 0);

    // Reversal at count 3, tick_cnt 2.
    fill_req = 1'b1;
    cyc();
    fill_req = 1'b0;
    ticks(14);
    chk("rev_pre_count", int'(count_0_7), 3);
    chk("rev_pre_tcnt", int'(dut.u_div.tick_cnt_o), 2);
    drain_req = 1'b1;
    tick = 1'b1;
    cyc();
    drain_req = 1'b0;
    tick = 1'b0;
    chk("rev_state", int'(dut.state_q), int'(StDrain));
    chk("rev_tcnt", int'(dut.u_div.tick_cnt_o), 0);
    chk("rev_count", int'(count_0_7), 3);
    chk("rev_dir", int'(direction), 0);
    ticks(4);
    chk("rev_count2", int'(count_0_7), 2);

    // Hold during FILL at count 2.
    fill_req = 1'b1;
    cyc();
    fill_req = 1'b0;
    chk("hold_state", int'(dut.state_q), int'(StFill));
    ticks(2);
    hold = 1'b1;
    ticks(10);
    chk("hold_count", int'(count_0_7), 2);
    chk("hold_tcnt", int'(dut.u_div.tick_cnt_o), 2);
    hold = 1'b0;
    ticks(1);
    chk("hold_resume_tcnt", int'(dut.u_div.tick_cnt_o), 3);
    chk("hold_resume_count", int'(count_0_7), 2);
    ticks(1);
    chk("hold_step_count", int'(count_0_7), 3);

    // Asynchronous reset mid-FILL at count 5.
    ticks(9);
    chk("mid_count5", int'(count_0_7), 5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_count", int'(count_0_7), 0);
    chk("async_moving", int'(moving), 0);
    chk("async_dir", int'(direction), 0);
    chk("async_empty", int'(empty), 1);
    chk("async_tcnt", int'(dut.u_div.tick_cnt_o), 0);
    @(negedge clk);
    reset = 1'b0;

    // Both requests in IDLE at count 4.
    fill2 = 1'b1;
    drain2 = 1'b1;
    tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("both_idle_count", int'(count2), 4);
      chk("both_idle_moving", int'(moving2), 0);
    end
    tick = 1'b0;
    fill2 = 1'b0;
    drain2 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
